// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcode definitions shared by seq_alu and its testbench.
package seq_alu_pkg;

    typedef enum logic [3:0] {
        kAdd  = 4'd0,
        kAddc = 4'd1,
        kSub  = 4'd2,
        kSll  = 4'd3,
        kSra  = 4'd4,
        kAnd  = 4'd5,
        kOr   = 4'd6,
        kNeg  = 4'd7,
        kMul  = 4'd8
    } alu_op_t;

endpackage

// File: rtl/seq_alu_mul.sv
// seq_alu_mul: iterative shift-add multiplier, one partial product per cycle.
// The first step happens on start and the last step is presented combinationally with done.
module seq_alu_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic                 r_run;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   w_acc_nxt;

    assign w_acc_nxt = r_mplier[0] ? r_acc + r_mcand : r_acc;
    assign o_done    = r_run && (r_cnt == CW'(WIDTH - 1));
    assign o_product = w_acc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_run    <= 1'b1;
            r_cnt    <= CW'(1);
            r_acc    <= i_b[0] ? {{WIDTH{1'b0}}, i_a} : '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a} << 1;
            r_mplier <= i_b >> 1;
        end else if (r_run) begin
            r_run    <= !o_done;
            r_cnt    <= r_cnt + CW'(1);
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with valid/ready handshake and registered result/flags.
// Define SEQ_ALU_MUL_EN to build the iterative MUL; otherwise MUL is an illegal opcode.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             illegal
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_result;
    logic               r_cout, r_zero, r_neg, r_illegal;
    logic               w_accept, w_is_mul, w_mul_done, w_big_shift;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]   w_res, w_mul_lo;
    logic [WIDTH:0]     w_ext;
    logic               w_cout, w_ill, w_upd_carry, w_mul_hi_nz;

    assign w_accept    = in_valid && (r_state == S_IDLE);
    assign w_big_shift = 32'(b) >= WIDTH;
    assign w_mul_lo    = w_product[WIDTH-1:0];
    assign w_mul_hi_nz = |w_product[2*WIDTH-1:WIDTH];

`ifdef SEQ_ALU_MUL_EN
    assign w_is_mul = (op == kMul);
    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_accept && w_is_mul),
        .i_a       (a),
        .i_b       (b),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );
`else
    assign w_is_mul   = 1'b0;
    assign w_mul_done = 1'b0;
    assign w_product  = '0;
`endif

    always_comb begin
        w_res       = '0;
        w_ext       = '0;
        w_cout      = 1'b0;
        w_ill       = 1'b0;
        w_upd_carry = 1'b0;
        case (op)
            kAdd: begin
                w_ext       = {1'b0, a} + {1'b0, b};
                {w_cout, w_res} = w_ext;
                w_upd_carry = 1'b1;
            end
            kAddc: begin
                w_ext       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, r_carry};
                {w_cout, w_res} = w_ext;
                w_upd_carry = 1'b1;
            end
            kSub: begin
                // top bit of the extended difference is the borrow
                w_ext       = {1'b0, a} - {1'b0, b};
                w_res       = w_ext[WIDTH-1:0];
                w_cout      = ~w_ext[WIDTH];
                w_upd_carry = 1'b1;
            end
            kSll:    w_res = w_big_shift ? '0 : a << b;
            kSra:    w_res = w_big_shift ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> b);
            kAnd:    w_res = a & b;
            kOr:     w_res = a | b;
            kNeg:    w_res = ~a;
            default: w_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_is_mul ? S_BUSY : S_DONE;
            S_BUSY:  if (w_mul_done) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry   <= 1'b0;
            r_result  <= '0;
            r_cout    <= 1'b0;
            r_zero    <= 1'b0;
            r_neg     <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_result  <= w_res;
            r_cout    <= w_cout;
            r_zero    <= (w_res == '0);
            r_neg     <= w_res[WIDTH-1];
            r_illegal <= w_ill;
            if (w_upd_carry) r_carry <= w_cout;
        end else if ((r_state == S_BUSY) && w_mul_done) begin
            r_result  <= w_mul_lo;
            r_cout    <= w_mul_hi_nz;
            r_zero    <= (w_mul_lo == '0);
            r_neg     <= w_mul_lo[WIDTH-1];
            r_illegal <= 1'b0;
            r_carry   <= w_mul_hi_nz;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign cout      = r_cout;
    assign zero      = r_zero;
    assign neg       = r_neg;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed scoreboard bench for seq_alu at WIDTH=8; follows SEQ_ALU_MUL_EN.
module tb_seq_alu;
    import seq_alu_pkg::*;

    typedef struct packed {
        logic [7:0] result;
        logic       cout;
        logic       zero;
        logic       neg;
        logic       illegal;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    alu_op_t    op;
    logic [7:0] a, b, result;
    logic       cout, zero, neg, illegal;

    int   checks = 0;
    int   failures = 0;
    logic m_carry = 1'b0;
    exp_t q[$];

    seq_alu #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .zero      (zero),
        .neg       (neg),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // reference behaviour, written independently of the RTL structure
    function automatic exp_t model(input logic [3:0] opc, input logic [7:0] x, input logic [7:0] y);
        exp_t        e;
        logic [15:0] w;
        logic [7:0]  r;
        e = '0;
        e.lat = 1;
        r = x;
        case (opc)
            4'd0: begin w = 16'(x) + 16'(y); e.result = w[7:0]; e.cout = w[8]; m_carry = w[8]; end
            4'd1: begin w = 16'(x) + 16'(y) + 16'(m_carry); e.result = w[7:0]; e.cout = w[8]; m_carry = w[8]; end
            4'd2: begin e.result = x - y; e.cout = (x >= y); m_carry = e.cout; end
            4'd3: begin for (int i = 0; i < 8 && i < int'(y); i++) r = {r[6:0], 1'b0}; e.result = r; end
            4'd4: begin for (int i = 0; i < 8 && i < int'(y); i++) r = {r[7], r[7:1]}; e.result = r; end
            4'd5: e.result = x & y;
            4'd6: e.result = x | y;
            4'd7: e.result = ~x;
`ifdef SEQ_ALU_MUL_EN
            4'd8: begin w = 16'(x) * 16'(y); e.result = w[7:0]; e.cout = |w[15:8]; m_carry = e.cout; e.lat = 8; end
`endif
            default: e.illegal = 1'b1;
        endcase
        e.zero = (e.result == 8'h00);
        e.neg  = e.result[7];
        return e;
    endfunction

    // issue one op from IDLE, optionally stall in DONE for `hold` cycles with new requests pending
    task automatic run_op(input string tag, input logic [3:0] opc, input logic [7:0] x, input logic [7:0] y, input int hold);
        exp_t e;
        int   lat;
        q.push_back(model(opc, x, y));
        in_valid = 1'b1; op = alu_op_t'(opc); a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        e = q.pop_front();
        check({tag, ".lat"}, 32'(lat), 32'(e.lat));
        check({tag, ".result"}, 32'(result), 32'(e.result));
        check({tag, ".cout"}, 32'(cout), 32'(e.cout));
        check({tag, ".zero"}, 32'(zero), 32'(e.zero));
        check({tag, ".neg"}, 32'(neg), 32'(e.neg));
        check({tag, ".illegal"}, 32'(illegal), 32'(e.illegal));
        check({tag, ".in_ready_busy"}, 32'(in_ready), 32'(0));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; op = kSub; a = 8'h33 + 8'(i); b = 8'h11;
            @(posedge clk); #1;
            check({tag, ".hold_result"}, 32'(result), 32'(e.result));
            check({tag, ".hold_flags"}, 32'({cout, zero, neg, illegal}), 32'({e.cout, e.zero, e.neg, e.illegal}));
            check({tag, ".hold_valid"}, 32'(out_valid), 32'(1));
            check({tag, ".hold_in_ready"}, 32'(in_ready), 32'(0));
        end
        out_ready = 1'b1;
        in_valid = (hold > 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check({tag, ".ret_idle"}, 32'(in_ready), 32'(1));
        check({tag, ".ret_valid"}, 32'(out_valid), 32'(0));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = kAdd; a = '0; b = '0;
        #3;
        check("rst.in_ready", 32'(in_ready), 32'(1));
        check("rst.out_valid", 32'(out_valid), 32'(0));
        check("rst.result", 32'(result), 32'(0));
        check("rst.flags", 32'({cout, zero, neg, illegal}), 32'(0));
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add_carry", 4'd0, 8'hF0, 8'h20, 0);
        run_op("addc_cin", 4'd1, 8'h00, 8'h00, 0);
        run_op("sub_eq", 4'd2, 8'h05, 8'h05, 0);
        run_op("sub_borrow", 4'd2, 8'h03, 8'h05, 0);
        run_op("sra3", 4'd4, 8'h80, 8'h03, 0);
        run_op("sra8", 4'd4, 8'h80, 8'h08, 0);
        run_op("sll9", 4'd3, 8'h01, 8'h09, 0);
        run_op("sll3", 4'd3, 8'h81, 8'h03, 0);
        run_op("and", 4'd5, 8'hC3, 8'h5A, 0);
        run_op("or", 4'd6, 8'hC3, 8'h5A, 0);
        run_op("neg", 4'd7, 8'h0F, 8'h00, 0);
        run_op("set_carry", 4'd0, 8'hFF, 8'h01, 0);
        run_op("undef", 4'd15, 8'h12, 8'h34, 0);
        run_op("addc_keep", 4'd1, 8'h00, 8'h00, 0);
        run_op("mul_a", 4'd8, 8'h0F, 8'h11, 0);
        run_op("mul_b", 4'd8, 8'h10, 8'h10, 0);
        run_op("stall", 4'd0, 8'h7F, 8'h01, 5);
        for (int i = 0; i < 6; i++)
            run_op("rnd", 4'($urandom_range(0, 8)), 8'($urandom), 8'($urandom), 0);

        // abandon an in-flight op with reset; the carry must come back cleared
        run_op("pre_rst", 4'd0, 8'hFF, 8'h01, 0);
        in_valid = 1'b1; a = 8'h03; b = 8'h05;
`ifdef SEQ_ALU_MUL_EN
        op = kMul;
`else
        op = kAdd;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst.out_valid", 32'(out_valid), 32'(0));
        check("midrst.in_ready", 32'(in_ready), 32'(1));
        check("midrst.result", 32'(result), 32'(0));
        check("midrst.cout", 32'(cout), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        m_carry = 1'b0;
        @(posedge clk); #1;
        check("postrst.out_valid", 32'(out_valid), 32'(0));
        check("postrst.in_ready", 32'(in_ready), 32'(1));
        run_op("addc_after_rst", 4'd1, 8'h00, 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width in bits; legal range 4..32.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  in  1  operation request valid.
REQ-005 SHALL have port in_ready  out  1  block can accept a request.
REQ-006 SHALL have port op  in  4  opcode, type alu_op_t.
REQ-007 SHALL have ports a, b  in  WIDTH  operands; for shifts b is the shift amount.
REQ-008 SHALL have port out_valid  out  1  result valid.
REQ-009 SHALL have port out_ready  in  1  consumer takes result.
REQ-010 SHALL have port result  out  WIDTH  registered result.
REQ-011 SHALL have ports cout, zero, neg, illegal  out  1 each  registered flags for the current result.

Function
REQ-012 SHALL implement FSM IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-013 SHALL accept on in_valid&&in_ready, latching op, a, b at that edge.
REQ-014 Single-cycle ops (ADD, ADDC, SUB, SLL, SRA, AND, OR, NEG) SHALL go IDLE->DONE, out_valid high the cycle after acceptance.
REQ-015 MUL SHALL go IDLE->BUSY, run one shift-add step per cycle, enter DONE exactly WIDTH cycles after acceptance.
REQ-016 In DONE, result and flags SHALL stay stable until out_valid&&out_ready, then return to IDLE; no new request accepted in that same cycle.
REQ-017 ADD: {cout,result}=a+b; ADDC: {cout,result}=a+b+carry_q; SUB: result=a-b, cout=1 when no borrow (a>=b unsigned).
REQ-018 SLL: a<<b, result 0 when b>=WIDTH; SRA: arithmetic right shift by b, all sign bits when b>=WIDTH; AND, OR: bitwise; NEG: ~a; these ops SHALL have cout=0.
REQ-019 MUL: result=low WIDTH bits of unsigned a*b; cout=1 when high WIDTH bits are nonzero.
REQ-020 zero SHALL equal (result==0); neg SHALL equal result[WIDTH-1].
REQ-021 Any undefined opcode SHALL produce result=0, zero=1, cout=0, illegal=1 after the single-cycle latency; carry_q unchanged.
REQ-022 Internal carry_q SHALL update only on entry to DONE for ADD, ADDC, SUB, MUL, taking that op's cout.
REQ-023 in_valid while BUSY or DONE SHALL be ignored and leave state unaffected.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, carry_q=0, result=0, cout=0, zero=0, neg=0, illegal=0, out_valid=0, in_ready=1.
REQ-025 Reset during BUSY or DONE SHALL abandon the operation with no result delivered.

Configuration
REQ-026 With SEQ_ALU_MUL_EN defined, MUL SHALL be implemented per REQ-015/019.
REQ-027 Without SEQ_ALU_MUL_EN, no multiplier logic SHALL exist, MUL SHALL be handled as an undefined opcode (REQ-021), and BUSY SHALL be unreachable.

Structure
REQ-028 Opcode enum alu_op_t (existing kAdd..kNeg plus new kMul) SHALL live in package definitions; FSM state enum stays local.
REQ-029 The iterative multiplier SHALL be sub-module seq_alu_mul (start, a, b -> done, product), instantiated only under SEQ_ALU_MUL_EN.

Verification (WIDTH=8)
REQ-030 ADD 0xF0+0x20 -> result 0x10, cout=1; then ADDC 0x00+0x00 -> 0x01, cout=0, zero=0.
REQ-031 SUB 0x05-0x05 -> 0x00, zero=1, cout=1; then SUB 0x03-0x05 -> 0xFE, neg=1, cout=0.
REQ-032 SRA 0x80 by 3 -> 0xF0; SRA 0x80 by 8 -> 0xFF; SLL 0x01 by 9 -> 0x00, zero=1.
REQ-033 MUL 0x0F*0x11 -> 0xFF, cout=0, out_valid exactly 8 cycles after accept; MUL 0x10*0x10 -> 0x00, cout=1, zero=1.
REQ-034 out_ready held 0 for 5 cycles in DONE with in_valid=1 and new operands -> result/flags unchanged, in_ready=0, no request accepted.
REQ-035 rst_n low in 3rd MUL cycle -> out_valid=0 at once, in_ready=1 after release, next ADDC 0+0 -> 0x00; without SEQ_ALU_MUL_EN, MUL -> illegal=1, result 0x00.
